// File: rtl/word_counter_bank_if.sv
// -----------------------------------------------------------------------------
// word_counter_bank_if
//
// Bundles the FIFO pop lines, the idle status and the probe-side read port of
// word_counter_bank into one interface.
//
// Parameters
//   NCH  number of channels (1..16)
//   CW   counter / count_out width
//   IW   read index width (2^IW >= NCH)
//
// Signals
//   pop       [NCH]  one pulse per word removed from output FIFO i
//   idle      [1]    main state machine is in IDLE
//   req       [1]    read request
//   idx       [IW]   channel to read, sampled with req
//   valid     [1]    count_out holds a fresh read result
//   count_out [CW]   value of the requested counter
//   err       [1]    one-cycle pulse for a request with idx >= NCH
//   overflow  [NCH]  sticky per-channel saturation flags
//
// Modports
//   master  probe / FIFO side (drives pop, idle, req, idx)
//   slave   the counter bank  (drives valid, count_out, err, overflow)
// -----------------------------------------------------------------------------
interface word_counter_bank_if #(
  parameter int NCH = 4,
  parameter int CW  = 5,
  parameter int IW  = 2
);
  logic [NCH-1:0] pop;
  logic           idle;
  logic           req;
  logic [IW-1:0]  idx;
  logic           valid;
  logic [CW-1:0]  count_out;
  logic           err;
  logic [NCH-1:0] overflow;

  modport master (
    output pop, idle, req, idx,
    input  valid, count_out, err, overflow
  );

  modport slave (
    input  pop, idle, req, idx,
    output valid, count_out, err, overflow
  );
endinterface : word_counter_bank_if

// File: rtl/word_counter_bank.sv
// -----------------------------------------------------------------------------
// word_counter_bank
//
// One saturating word counter per output FIFO, incremented on every pop, with
// an indexed, registered read port that is only served while the main state
// machine reports IDLE.
//
// Parameters
//   NCH  number of channels (1..16)
//   CW   counter / count_out width
//   IW   read index width (2^IW >= NCH)
//
// Ports
//   clk    single clock, all logic on the rising edge
//   reset  synchronous, active-high; overrides every other input
//   bus    word_counter_bank_if.slave (pop, idle, req, idx in;
//          valid, count_out, err, overflow out)
//
// Build option
//   WCB_CLEAR_ON_READ_EN  when defined, an accepted read of channel i clears
//                         counter[i] and overflow[i] on the same edge; a pop on
//                         that edge leaves the counter at 1.
// -----------------------------------------------------------------------------
module word_counter_bank #(
  parameter int NCH = 4,
  parameter int CW  = 5,
  parameter int IW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  word_counter_bank_if.slave  bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Per-channel state
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] ovf_q, ovf_d;

  // Read-port registers
  logic           valid_q, valid_d;
  logic           err_q,   err_d;
  logic [CW-1:0]  count_q, count_d;

  // Read decode
  logic           idx_in_range;
  logic           rd_accept;
  logic [NCH-1:0] rd_sel;
  logic [CW-1:0]  rd_val;
  logic [NCH-1:0] clr;
  logic [CW-1:0]  base;

  // ---------------------------------------------------------------------------
  // Read decode and response
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_in_range = 32'(bus.idx) < NCH;
    rd_accept    = bus.req && bus.idle && idx_in_range;

    rd_sel = '0;
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_sel[i] = (32'(bus.idx) == i);
      if (rd_sel[i]) rd_val = cnt_q[i];
    end

    // Requests while not idle are dropped outright: no error, no result.
    valid_d = rd_accept;
    err_d   = bus.req && bus.idle && !idx_in_range;
    // count_out keeps the last read value unless a new read is accepted.
    count_d = rd_accept ? rd_val : count_q;
  end

  // ---------------------------------------------------------------------------
  // Counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef WCB_CLEAR_ON_READ_EN
    clr = rd_accept ? rd_sel : '0;
`else
    clr = '0;
`endif
    base = '0;
    for (int i = 0; i < NCH; i++) begin
      // A clearing read restarts from zero, so a same-edge pop still counts.
      base     = clr[i] ? '0 : cnt_q[i];
      cnt_d[i] = base;
      ovf_d[i] = ovf_q[i] & ~clr[i];
      if (bus.pop[i]) begin
        if (base == CNT_MAX) ovf_d[i] = 1'b1;
        else                 cnt_d[i] = base + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset explicitly; every counter must read 0 after reset.
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.count_out = count_q;
  assign bus.overflow  = ovf_q;

endmodule : word_counter_bank

// File: tb/tb_word_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_word_counter_bank
//
// Drives a 4-channel bank with directed scenarios followed by random traffic
// and compares every output after every edge against a behavioural model of
// the counters. A second 3-channel bank exercises the out-of-range index case.
// -----------------------------------------------------------------------------
module tb_word_counter_bank;

  localparam int NCH  = 4;
  localparam int CW   = 5;
  localparam int IW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  word_counter_bank_if #(.NCH(NCH), .CW(CW), .IW(IW)) bus ();
  word_counter_bank #(.NCH(NCH), .CW(CW), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  word_counter_bank_if #(.NCH(3), .CW(CW), .IW(IW)) bus3 ();
  word_counter_bank #(.NCH(3), .CW(CW), .IW(IW)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  // Reference model: word counts saturate at MAXV, reads see pre-edge counts.
  int m_cnt [NCH];
  bit m_ovf [NCH];
  int e_count;
  bit e_valid, e_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [NCH-1:0] model_ovf();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"},    32'(bus.valid),     32'(e_valid));
    check({tag, ".err"},      32'(bus.err),       32'(e_err));
    check({tag, ".count"},    32'(bus.count_out), 32'(e_count));
    check({tag, ".overflow"}, 32'(bus.overflow),  32'(model_ovf()));
  endtask

  // One clock edge on the main bank: drive, advance the model, check.
  task automatic cycle(input logic [NCH-1:0] p, input bit idl, input bit rq,
                       input int ix, input bit rst, input string tag);
    bit acc;
    bit clr_on_read;
`ifdef WCB_CLEAR_ON_READ_EN
    clr_on_read = 1'b1;
`else
    clr_on_read = 1'b0;
`endif
    reset    = rst;
    bus.pop  = p;
    bus.idle = idl;
    bus.req  = rq;
    bus.idx  = IW'(ix);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      e_valid = 0;
      e_err   = 0;
      e_count = 0;
    end else begin
      acc     = rq && idl && (ix < NCH);
      e_valid = acc;
      e_err   = rq && idl && (ix >= NCH);
      if (acc) e_count = m_cnt[ix];
      for (int i = 0; i < NCH; i++) begin
        if (clr_on_read && acc && ix == i) begin
          m_cnt[i] = 0;
          m_ovf[i] = 0;
        end
        if (p[i]) begin
          if (m_cnt[i] == MAXV) m_ovf[i] = 1;
          else                  m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus3.pop  = '0;
    bus3.idle = 1'b0;
    bus3.req  = 1'b0;
    bus3.idx  = '0;

    // Reset state
    cycle('0, 0, 0, 0, 1, "reset");
    check("reset3.valid", 32'(bus3.valid), 32'd0);
    check("reset3.err",   32'(bus3.err),   32'd0);
    check("reset3.count", 32'(bus3.count_out), 32'd0);

    // NCH=3 bank: two pops on ch0, read it, then an out-of-range index.
    bus3.pop = 3'b001;
    cycle('0, 0, 0, 0, 0, "idle_a");
    cycle('0, 0, 0, 0, 0, "idle_b");
    bus3.pop = 3'b000; bus3.req = 1'b1; bus3.idle = 1'b1; bus3.idx = 2'd0;
    cycle('0, 0, 0, 0, 0, "idle_c");
    check("n3_read.valid", 32'(bus3.valid), 32'd1);
    check("n3_read.count", 32'(bus3.count_out), 32'd2);
    bus3.idx = 2'd3;
    cycle('0, 0, 0, 0, 0, "idle_d");
    check("n3_oob.err",   32'(bus3.err),   32'd1);
    check("n3_oob.valid", 32'(bus3.valid), 32'd0);
    check("n3_oob.count", 32'(bus3.count_out), 32'd2);
    bus3.req = 1'b0;
    cycle('0, 0, 0, 0, 0, "idle_e");
    check("n3_after.err", 32'(bus3.err), 32'd0);
    check("n3_after.ovf", 32'(bus3.overflow), 32'd0);
    bus3.idle = 1'b0;

    // Four pops on every channel, then back-to-back reads of 0..3.
    cycle('0, 0, 0, 0, 1, "rst1");
    for (int k = 0; k < 4; k++) cycle(4'hF, 0, 0, 0, 0, "pop4");
    for (int c = 0; c < 4; c++) begin
      cycle('0, 1, 1, c, 0, "b2b");
      check("b2b.const", 32'(bus.count_out), 32'd4);
    end

    // Saturation of channel 2.
    cycle('0, 0, 0, 0, 1, "rst2");
    for (int k = 0; k < 33; k++) cycle(4'b0100, 0, 0, 0, 0, "sat_pop");
    cycle('0, 1, 1, 2, 0, "sat_read");
    check("sat.count", 32'(bus.count_out), 32'(MAXV));
    check("sat.ovf",   32'(bus.overflow), 32'b0100);

    // Request while busy is ignored, then served once idle.
    cycle(4'b0010, 0, 0, 0, 0, "busy_pop");
    cycle('0, 0, 1, 1, 0, "busy_req");
    check("busy.valid", 32'(bus.valid), 32'd0);
    cycle('0, 1, 1, 1, 0, "idle_req");
    check("idle.valid", 32'(bus.valid), 32'd1);

    // Same-edge pop and read of channel 1 holding 5.
    cycle('0, 0, 0, 0, 1, "rst3");
    for (int k = 0; k < 5; k++) cycle(4'b0010, 0, 0, 0, 0, "ch1_pop");
    cycle(4'b0010, 1, 1, 1, 0, "ch1_rd_pop");
    check("ch1.pre", 32'(bus.count_out), 32'd5);
    cycle('0, 1, 1, 1, 0, "ch1_rd2");
`ifdef WCB_CLEAR_ON_READ_EN
    check("ch1.next", 32'(bus.count_out), 32'd1);
`else
    check("ch1.next", 32'(bus.count_out), 32'd6);
`endif

    // Reset mid-burst, then count only post-reset pops.
    for (int k = 0; k < 3; k++) cycle(4'hF, 1, 1, k, 0, "burst");
    cycle(4'hF, 1, 1, 3, 1, "burst_rst");
    check("burst_rst.valid", 32'(bus.valid), 32'd0);
    cycle(4'b1000, 0, 1, 3, 0, "post_pop");
    cycle(4'b1000, 0, 1, 3, 0, "post_pop");
    cycle('0, 1, 1, 3, 0, "post_read");
    check("post.count", 32'(bus.count_out), 32'd2);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [NCH-1:0] p;
      p = NCH'($urandom) & NCH'($urandom | $urandom);
      cycle(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 127) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_word_counter_bank
